// File: rtl/fc_state_tx.sv
// Transmit-side FC_Port state sequencer: emits link primitives for the effective
// port state and gates client frames onto the link while Active, with hold-off and IFG idles.
package fc_state_pkg;
    typedef enum logic [3:0] {
        AC  = 4'd0,
        LR1 = 4'd1,
        LR2 = 4'd2,
        LR3 = 4'd3,
        LF1 = 4'd4,
        LF2 = 4'd5,
        OL1 = 4'd6,
        OL2 = 4'd7,
        OL3 = 4'd8
    } state_t;
endpackage

module fc_state_tx
    import fc_state_pkg::*;
#(
    parameter int MIN_IDLES = 6,
    parameter int IFG_IDLES = 6,
    parameter int ABORT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  state_t             rx_state,
    input  logic               local_fault,
    input  logic               lr_req,
    input  logic [31:0]        tx_data,
    input  logic [3:0]         tx_datak,
    input  logic               tx_sop,
    input  logic               tx_eop,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic [31:0]        data,
    output logic [3:0]         datak,
    output state_t             tx_state,
    output logic [ABORT_W-1:0] abort_count
);
    localparam logic [31:0] W_OLS  = 32'hBC358A55;
    localparam logic [31:0] W_NOS  = 32'hBC55BF45;
    localparam logic [31:0] W_LR   = 32'hBC49BF49;
    localparam logic [31:0] W_LRR  = 32'hBC35BF49;
    localparam logic [31:0] W_IDLE = 32'hBC95B5B5;
    localparam logic [3:0]  K_PRIM = 4'b1000;

    typedef enum logic [2:0] {
        S_HOLD    = 3'd0,
        S_HOLDOFF = 3'd1,
        S_READY   = 3'd2,
        S_FRAME   = 3'd3,
        S_IFG     = 3'd4,
        S_DRAIN   = 3'd5
    } fsm_t;

    fsm_t               r_state;
    fsm_t               w_state_nxt;
    logic [7:0]         r_cnt;
    logic [7:0]         w_cnt_nxt;
    logic               r_lr_ovr;
    logic               r_tx_ready;
    logic [31:0]        r_data;
    logic [3:0]         r_datak;
    state_t             r_tx_state;
    logic [ABORT_W-1:0] r_abort;
    state_t             w_eff;
    logic               w_accept;
    logic               w_abort_inc;
    logic [31:0]        w_data_nxt;
    logic [3:0]         w_datak_nxt;
    logic [31:0]        w_prim;

    // The LR override only applies while the receiver still reports Active.
    assign w_eff    = local_fault ? LF2 :
                      (r_lr_ovr && (rx_state == AC)) ? LR1 : rx_state;
    assign w_accept = tx_valid & r_tx_ready;

    // Primitive word for the effective state
    always_comb begin
        w_prim = W_NOS;
        case (w_eff)
            OL1, LF1: w_prim = W_OLS;
            OL2, LR1: w_prim = W_LR;
            OL3, LF2: w_prim = W_NOS;
            LR2:      w_prim = W_LRR;
            LR3:      w_prim = W_IDLE;
            AC:       w_prim = W_IDLE;
            default:  w_prim = W_NOS;
        endcase
    end

    // Next-state, next link word and abort strobe
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_abort_inc = 1'b0;
        w_data_nxt  = W_IDLE;
        w_datak_nxt = K_PRIM;
        if (w_eff == AC) begin
            case (r_state)
                S_HOLD: begin
                    // The HOLD cycle already contributes one idle to the hold-off.
                    w_state_nxt = S_HOLDOFF;
                    w_cnt_nxt   = 8'(MIN_IDLES - 1);
                end
                S_HOLDOFF, S_IFG: begin
                    if (r_cnt <= 8'd1) begin
                        w_state_nxt = S_READY;
                    end else begin
                        w_cnt_nxt = r_cnt - 8'd1;
                    end
                end
                S_READY, S_FRAME: begin
                    if (w_accept && (tx_sop || (r_state == S_FRAME))) begin
                        w_data_nxt  = tx_data;
                        w_datak_nxt = tx_datak;
                        if (tx_eop) begin
                            w_state_nxt = S_IFG;
                            w_cnt_nxt   = 8'(IFG_IDLES);
                        end else begin
                            w_state_nxt = S_FRAME;
                        end
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                S_DRAIN: begin
                    if (w_accept && tx_eop) begin
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_state_nxt = S_DRAIN;
                    end
                end
                default: w_state_nxt = S_HOLD;
            endcase
        end else begin
            w_data_nxt = w_prim;
            case (r_state)
                S_FRAME: begin
                    w_abort_inc = 1'b1;
                    if (w_accept && tx_eop) begin
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_state_nxt = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_accept && tx_eop) begin
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_state_nxt = S_DRAIN;
                    end
                end
                default: w_state_nxt = S_HOLD;
            endcase
        end
    end

    // State, counters, override and registered link outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_HOLD;
            r_cnt      <= 8'd0;
            r_lr_ovr   <= 1'b0;
            r_tx_ready <= 1'b0;
            r_data     <= W_NOS;
            r_datak    <= K_PRIM;
            r_tx_state <= LF2;
            r_abort    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_tx_ready <= (w_state_nxt == S_READY) || (w_state_nxt == S_FRAME) ||
                          (w_state_nxt == S_DRAIN);
            r_data     <= w_data_nxt;
            r_datak    <= w_datak_nxt;
            r_tx_state <= w_eff;
            if (local_fault || (rx_state != AC)) begin
                r_lr_ovr <= 1'b0;
            end else if (lr_req) begin
                r_lr_ovr <= 1'b1;
            end
            if (w_abort_inc && !(&r_abort)) begin
                r_abort <= r_abort + 1'b1;
            end
        end
    end

    assign tx_ready    = r_tx_ready;
    assign data        = r_data;
    assign datak       = r_datak;
    assign tx_state    = r_tx_state;
    assign abort_count = r_abort;
endmodule

// File: tb/tb_fc_state_tx.sv
// Cycle-stepped bench for fc_state_tx: each driven cycle pushes the expected link word
// into a scoreboard queue that is popped and compared once the DUT has registered it.
module tb_fc_state_tx;
    import fc_state_pkg::*;

    localparam logic [31:0] OLS  = 32'hBC358A55;
    localparam logic [31:0] NOS  = 32'hBC55BF45;
    localparam logic [31:0] LRW  = 32'hBC49BF49;
    localparam logic [31:0] LRR  = 32'hBC35BF49;
    localparam logic [31:0] IDLE = 32'hBC95B5B5;
    localparam logic [3:0]  KP   = 4'b1000;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    state_t      rx_state;
    logic        local_fault;
    logic        lr_req;
    logic [31:0] tx_data;
    logic [3:0]  tx_datak;
    logic        tx_sop;
    logic        tx_eop;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] data;
    logic [3:0]  datak;
    state_t      tx_state;
    logic [1:0]  abort_count;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    fc_state_tx #(.MIN_IDLES(6), .IFG_IDLES(6), .ABORT_W(2)) dut (
        .clk(clk), .reset(reset), .rx_state(rx_state), .local_fault(local_fault),
        .lr_req(lr_req), .tx_data(tx_data), .tx_datak(tx_datak), .tx_sop(tx_sop),
        .tx_eop(tx_eop), .tx_valid(tx_valid), .tx_ready(tx_ready), .data(data),
        .datak(datak), .tx_state(tx_state), .abort_count(abort_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: check tx_ready for this cycle, drive, push expectation, then pop and compare.
    task automatic cyc(input state_t rx, input logic v, input logic s, input logic e,
                       input logic [31:0] d, input logic [3:0] k,
                       input logic [31:0] xd, input logic [3:0] xk, input logic xr);
        exp_t x;
        chk("tx_ready", 32'(tx_ready), 32'(xr));
        rx_state = rx; tx_valid = v; tx_sop = s; tx_eop = e; tx_data = d; tx_datak = k;
        sb_q.push_back('{d: xd, k: xk});
        @(posedge clk);
        @(negedge clk);
        lr_req = 1'b0;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            x = sb_q.pop_front();
            chk("data", data, x.d);
            chk("datak", 32'(datak), 32'(x.k));
        end
    endtask

    task automatic prim_cyc(input state_t rx, input logic [31:0] xd, input logic xr);
        cyc(rx, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, xd, KP, xr);
    endtask

    task automatic word_pass(input logic s, input logic e, input logic [31:0] d, input logic [3:0] k);
        cyc(AC, 1'b1, s, e, d, k, d, k, 1'b1);
    endtask

    task automatic word_drop(input state_t rx, input logic s, input logic e,
                             input logic [31:0] d, input logic [31:0] xd);
        cyc(rx, 1'b1, s, e, d, 4'h0, xd, KP, 1'b1);
    endtask

    task automatic idle6();
        for (int i = 0; i < 6; i++) prim_cyc(AC, IDLE, 1'b0);
    endtask

    initial begin
        reset = 1'b1; rx_state = LF2; local_fault = 1'b0; lr_req = 1'b0;
        tx_data = 32'h0; tx_datak = 4'h0; tx_sop = 1'b0; tx_eop = 1'b0; tx_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_data", data, NOS);
        chk("rst_datak", 32'(datak), 32'(KP));
        chk("rst_ready", 32'(tx_ready), 32'd0);
        chk("rst_state", 32'(tx_state), 32'(LF2));
        chk("rst_abort", 32'(abort_count), 32'd0);
        reset = 1'b0;

        // Primitive per receive state
        for (int i = 0; i < 3; i++) prim_cyc(LF2, NOS, 1'b0);
        prim_cyc(OL1, OLS, 1'b0);
        chk("st_ol1", 32'(tx_state), 32'(OL1));
        prim_cyc(LR2, LRR, 1'b0);
        prim_cyc(OL3, NOS, 1'b0);
        prim_cyc(OL3, NOS, 1'b0);

        // Active: 6 idles then a 4-word frame with an idle gap, then IFG
        idle6();
        word_pass(1'b1, 1'b0, 32'hBCB55656, 4'b1000);
        word_pass(1'b0, 1'b0, 32'h11110001, 4'b0000);
        cyc(AC, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, IDLE, KP, 1'b1);
        word_pass(1'b0, 1'b0, 32'h11110002, 4'b0000);
        word_pass(1'b0, 1'b1, 32'hBC95D5D5, 4'b1000);
        idle6();

        // Back-to-back frames with the next SOF held valid through IFG
        word_pass(1'b1, 1'b0, 32'hBCB5A0A0, 4'b1000);
        word_pass(1'b0, 1'b0, 32'h22220001, 4'b0000);
        word_pass(1'b0, 1'b1, 32'hBC95A1A1, 4'b1000);
        for (int i = 0; i < 6; i++)
            cyc(AC, 1'b1, 1'b1, 1'b0, 32'hBCB5B0B0, 4'b1000, IDLE, KP, 1'b0);
        word_pass(1'b1, 1'b0, 32'hBCB5B0B0, 4'b1000);
        word_pass(1'b0, 1'b1, 32'hBC95B1B1, 4'b1000);
        idle6();

        // Non-sop word in READY is dropped
        word_drop(AC, 1'b0, 1'b0, 32'hDEADBEEF, IDLE);
        prim_cyc(AC, IDLE, 1'b1);

        // Link loss on word 2 of 5, drain the rest
        word_pass(1'b1, 1'b0, 32'hBCB5C0C0, 4'b1000);
        word_drop(LF1, 1'b0, 1'b0, 32'h33330001, OLS);
        chk("abort_1", 32'(abort_count), 32'd1);
        word_drop(LF1, 1'b0, 1'b0, 32'h33330002, OLS);
        word_drop(LF1, 1'b0, 1'b0, 32'h33330003, OLS);
        word_drop(LF1, 1'b0, 1'b1, 32'h33330004, OLS);
        prim_cyc(LF1, OLS, 1'b0);
        chk("abort_1b", 32'(abort_count), 32'd1);
        idle6();
        word_pass(1'b1, 1'b1, 32'hBCB5C1C1, 4'b1000);
        idle6();

        // Link reset request from Active, then LR3 and back to Active
        lr_req = 1'b1;
        prim_cyc(AC, IDLE, 1'b1);
        prim_cyc(AC, LRW, 1'b1);
        prim_cyc(AC, LRW, 1'b0);
        chk("st_lr1", 32'(tx_state), 32'(LR1));
        lr_req = 1'b1;
        prim_cyc(LR3, IDLE, 1'b0);
        prim_cyc(LR3, IDLE, 1'b0);
        chk("st_lr3", 32'(tx_state), 32'(LR3));
        idle6();

        // Local fault mid-frame
        word_pass(1'b1, 1'b0, 32'hBCB5D0D0, 4'b1000);
        local_fault = 1'b1;
        word_drop(AC, 1'b0, 1'b0, 32'h44440001, NOS);
        chk("abort_2", 32'(abort_count), 32'd2);
        chk("st_lf2", 32'(tx_state), 32'(LF2));
        word_drop(AC, 1'b0, 1'b1, 32'h44440002, NOS);
        prim_cyc(AC, NOS, 1'b0);
        local_fault = 1'b0;
        idle6();

        // Loss coinciding with eop goes straight to HOLD
        word_pass(1'b1, 1'b0, 32'hBCB5E0E0, 4'b1000);
        word_drop(LF2, 1'b0, 1'b1, 32'h55550001, NOS);
        chk("abort_3", 32'(abort_count), 32'd3);
        prim_cyc(LF2, NOS, 1'b0);
        idle6();

        // Saturation
        word_pass(1'b1, 1'b0, 32'hBCB5F0F0, 4'b1000);
        word_drop(OL2, 1'b0, 1'b1, 32'h66660001, LRW);
        chk("abort_sat", 32'(abort_count), 32'd3);
        prim_cyc(OL2, LRW, 1'b0);
        idle6();

        // Reset mid-frame
        word_pass(1'b1, 1'b0, 32'hBCB5F1F1, 4'b1000);
        reset = 1'b1;
        cyc(AC, 1'b1, 1'b0, 1'b0, 32'h77770001, 4'h0, NOS, KP, 1'b1);
        chk("mrst_ready", 32'(tx_ready), 32'd0);
        chk("mrst_abort", 32'(abort_count), 32'd0);
        chk("mrst_state", 32'(tx_state), 32'(LF2));
        reset = 1'b0;
        prim_cyc(AC, IDLE, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
